// File: rtl/ahb_mtx_arb_param.sv
// Output-stage arbiter for the AHB bus matrix. It chooses which input port drives a shared slave port,
// using fixed-priority or round-robin selection, and it can hold the grant for the length of a defined burst.

// Per-port request lane. The port that currently holds the grant keeps requesting while its transfer is live.
module ahb_mtx_arb_req_lane #(
  parameter int ADDR_W   = 3,
  parameter int PORT_IDX = 0
) (
  input  logic              req,
  input  logic              active,
  input  logic [ADDR_W-1:0] addr_in_port,
  output logic              eff_req
);
  assign eff_req = req | (active & (addr_in_port == ADDR_W'(PORT_IDX)));
endmodule

module ahb_mtx_arb_param #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_BASE  = 0,
  parameter int ADDR_W     = 3,
  parameter int RR_MODE    = 0,
  parameter int BURST_HOLD = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [ADDR_W-1:0]    addr_in_port,
  output logic                 no_port
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_BUSY = 2'b01;
  localparam logic [1:0] TR_NSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ  = 2'b11;

  logic [IDX_W-1:0]     rr_ptr;
  logic [3:0]           beat_cnt, beat_cnt_nxt;
  logic                 active;
  logic [NUM_PORTS-1:0] eff_req;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_vld;
  logic [ADDR_W-1:0]    addr_nxt;
  logic                 no_port_nxt;
  logic                 rr_load;

  assign active = ~no_port & HSELM & (HTRANSM != TR_IDLE);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    ahb_mtx_arb_req_lane #(
      .ADDR_W   (ADDR_W),
      .PORT_IDX (PORT_BASE + i)
    ) u_lane (
      .req          (req_port[i]),
      .active       (active),
      .addr_in_port (addr_in_port),
      .eff_req      (eff_req[i])
    );
  end

  // The scan runs downward, so the last hit it records is the one with the highest priority.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand    = '0;
    win_idx = '0;
    win_vld = 1'b0;
    if (RR_MODE == 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (eff_req[i]) begin
          win_idx = IDX_W'(i);
          win_vld = 1'b1;
        end
      end
    end else begin
      for (int j = NUM_PORTS; j >= 1; j--) begin
        cand = IDX_W'((int'(rr_ptr) + j) % NUM_PORTS);
        if (eff_req[cand]) begin
          win_idx = cand;
          win_vld = 1'b1;
        end
      end
    end
  end

  // Remaining SEQ beats of a defined-length burst. A BUSY beat holds the count.
  always_comb begin
    beat_cnt_nxt = 4'd0;
    if (BURST_HOLD != 0) begin
      case (HTRANSM)
        TR_NSEQ: begin
          if (HSELM) begin
            case (HBURSTM)
              3'b010, 3'b011: beat_cnt_nxt = 4'd3;
              3'b100, 3'b101: beat_cnt_nxt = 4'd7;
              3'b110, 3'b111: beat_cnt_nxt = 4'd15;
              default:        beat_cnt_nxt = 4'd0;
            endcase
          end
        end
        TR_SEQ:  if (HSELM && beat_cnt != 4'd0) beat_cnt_nxt = beat_cnt - 4'd1;
        TR_BUSY: beat_cnt_nxt = beat_cnt;
        default: beat_cnt_nxt = 4'd0;
      endcase
    end
  end

  always_comb begin
    addr_nxt    = addr_in_port;
    no_port_nxt = no_port;
    rr_load     = 1'b0;
    if (!HMASTLOCKM) begin
      if (beat_cnt_nxt != 4'd0) begin
        no_port_nxt = 1'b0;
      end else if (win_vld) begin
        addr_nxt    = ADDR_W'(PORT_BASE) + ADDR_W'(win_idx);
        no_port_nxt = 1'b0;
        rr_load     = 1'b1;
      end else if (HSELM) begin
        no_port_nxt = 1'b0;
      end else begin
        no_port_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_in_port <= ADDR_W'(PORT_BASE);
      no_port      <= 1'b1;
      rr_ptr       <= '0;
      beat_cnt     <= 4'd0;
    end else if (HREADYM) begin
      addr_in_port <= addr_nxt;
      no_port      <= no_port_nxt;
      beat_cnt     <= beat_cnt_nxt;
      if (rr_load) rr_ptr <= win_idx;
    end
  end
endmodule

// File: tb/tb_ahb_mtx_arb_param.sv
// Bench for ahb_mtx_arb_param. Three arbiter configurations share one stimulus stream and are compared
// against a transaction-level model: fixed priority at base 0, fixed priority at base 2, and round-robin.
module tb_ahb_mtx_arb_param;
  logic       HCLK = 1'b0;
  logic       HRESET, HREADYM, HSELM, HMASTLOCKM;
  logic [3:0] req_port;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic [2:0] addr_fp, addr_fb, addr_rr;
  logic       np_fp, np_fb, np_rr;

  int vecs = 0;
  int miss = 0;

  // Per-configuration model state: granted port offset, idle flag, last round-robin winner, beats left.
  int m_port[3], m_none[3], m_last[3], m_rem[3];
  int base[3] = '{0, 2, 0};
  int rrm[3]  = '{0, 0, 1};

  always #5 HCLK = ~HCLK;

  ahb_mtx_arb_param u_fp (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM), .HSELM(HSELM),
    .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(addr_fp), .no_port(np_fp));

  ahb_mtx_arb_param #(.PORT_BASE(2)) u_fb (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM), .HSELM(HSELM),
    .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(addr_fb), .no_port(np_fb));

  ahb_mtx_arb_param #(.RR_MODE(1)) u_rr (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM), .HSELM(HSELM),
    .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(addr_rr), .no_port(np_rr));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A burst of the given type carries len beats: one NONSEQ followed by len-1 SEQ beats.
  function automatic int burst_len(input logic [2:0] hb);
    if (hb < 3'd2) return 1;
    return 4 << ((int'(hb) - 2) / 2);
  endfunction

  task automatic model(input int k);
    bit active, any;
    bit eff[4];
    int nrem, win;
    if (HRESET) begin
      m_port[k] = 0; m_none[k] = 1; m_last[k] = 0; m_rem[k] = 0;
      return;
    end
    if (!HREADYM) return;
    active = !m_none[k] && HSELM && HTRANSM != 2'b00;
    any = 0;
    for (int i = 0; i < 4; i++) begin
      eff[i] = req_port[i] || (active && m_port[k] == i);
      any |= eff[i];
    end
    if (HTRANSM == 2'b10 && HSELM)      nrem = burst_len(HBURSTM) - 1;
    else if (HTRANSM == 2'b11 && HSELM) nrem = (m_rem[k] > 0) ? m_rem[k] - 1 : 0;
    else if (HTRANSM == 2'b01)          nrem = m_rem[k];
    else                                nrem = 0;
    if (HMASTLOCKM) begin
    end else if (nrem != 0) begin
      m_none[k] = 0;
    end else if (any) begin
      win = -1;
      if (rrm[k] == 0) begin
        for (int i = 3; i >= 0; i--) if (eff[i]) win = i;
      end else begin
        for (int d = 4; d >= 1; d--) if (eff[(m_last[k] + d) % 4]) win = (m_last[k] + d) % 4;
      end
      m_port[k] = win; m_last[k] = win; m_none[k] = 0;
    end else begin
      m_none[k] = HSELM ? 0 : 1;
    end
    m_rem[k] = nrem;
  endtask

  task automatic step(input string tag);
    logic [7:0] a[3];
    logic       n[3];
    for (int k = 0; k < 3; k++) model(k);
    @(posedge HCLK); #1;
    a[0] = {5'd0, addr_fp}; a[1] = {5'd0, addr_fb}; a[2] = {5'd0, addr_rr};
    n[0] = np_fp; n[1] = np_fb; n[2] = np_rr;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.u%0d.addr", tag, k), a[k], 8'(base[k] + m_port[k]));
      chk($sformatf("%s.u%0d.no_port", tag, k), {7'd0, n[k]}, 8'(m_none[k]));
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic s, input logic [1:0] t,
                       input logic [2:0] b, input logic l, input logic rdy);
    req_port = r; HSELM = s; HTRANSM = t; HBURSTM = b; HMASTLOCKM = l; HREADYM = rdy;
  endtask

  initial begin
    HRESET = 1'b1;
    drive(4'b1111, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
    step("rst0");
    step("rst1");
    chk("rst_addr", {5'd0, addr_fp}, 8'd0);
    chk("rst_np", {7'd0, np_fp}, 8'd1);
    chk("rst_base", {5'd0, addr_fb}, 8'd2);
    HRESET = 1'b0;
    step("rel");
    chk("rel_addr", {5'd0, addr_fp}, 8'd0);
    chk("rel_np", {7'd0, np_fp}, 8'd0);

    // Fixed priority at base 2
    drive(4'b1100, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
    step("fp_a");
    chk("fp_addr4", {5'd0, addr_fb}, 8'd4);
    drive(4'b1110, 1'b1, 2'b00, 3'b000, 1'b0, 1'b1);
    step("fp_b");
    chk("fp_addr3", {5'd0, addr_fb}, 8'd3);

    // Round-robin rotation with every port requesting
    drive(4'b1111, 1'b1, 2'b00, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step("rr");

    // INCR4 from port 1 with a wait state in the middle; port 0 requests throughout
    drive(4'b0010, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
    step("b4_pre");
    drive(4'b0011, 1'b1, 2'b10, 3'b011, 1'b0, 1'b1);
    step("b4_ns");
    chk("b4_hold", {5'd0, addr_fp}, 8'd1);
    drive(4'b0011, 1'b1, 2'b11, 3'b011, 1'b0, 1'b1);
    step("b4_s1");
    HREADYM = 1'b0;
    step("b4_wait");
    chk("b4_wait_hold", {5'd0, addr_fp}, 8'd1);
    HREADYM = 1'b1;
    step("b4_s2");
    chk("b4_s2_hold", {5'd0, addr_fp}, 8'd1);
    step("b4_s3");
    chk("b4_switch", {5'd0, addr_fp}, 8'd0);

    // INCR8 cut short by IDLE
    drive(4'b0010, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
    step("b8_pre");
    drive(4'b0011, 1'b1, 2'b10, 3'b101, 1'b0, 1'b1);
    step("b8_ns");
    drive(4'b0011, 1'b1, 2'b11, 3'b101, 1'b0, 1'b1);
    step("b8_s1");
    chk("b8_hold", {5'd0, addr_fp}, 8'd1);
    drive(4'b0011, 1'b1, 2'b00, 3'b101, 1'b0, 1'b1);
    step("b8_idle");
    chk("b8_rearb", {5'd0, addr_fp}, 8'd0);

    // Lock against a higher-priority request, then a reset in the middle of a WRAP16
    drive(4'b0010, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
    step("lk_pre");
    drive(4'b0011, 1'b1, 2'b10, 3'b000, 1'b1, 1'b1);
    step("lk");
    chk("lk_hold", {5'd0, addr_fp}, 8'd1);
    drive(4'b0011, 1'b1, 2'b10, 3'b110, 1'b0, 1'b1);
    step("w16_ns");
    drive(4'b0011, 1'b1, 2'b11, 3'b110, 1'b0, 1'b1);
    step("w16_s1");
    step("w16_s2");
    HRESET = 1'b1;
    HREADYM = 1'b0;
    step("w16_rst");
    chk("w16_rst_addr", {5'd0, addr_fp}, 8'd0);
    chk("w16_rst_np", {7'd0, np_fp}, 8'd1);
    HRESET = 1'b0;
    HREADYM = 1'b1;
    step("w16_rel");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      HRESET = ($urandom_range(0, 39) == 0);
      drive(4'($urandom), $urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
